// File: rtl/partial_sum_accumulator_pkg.sv
// Shared types for the partial-sum accumulator: FSM state enum and term-counter width helper.
package acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Width of a counter that spans 0..terms-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned terms);
        return (terms <= 1) ? 1 : $clog2(terms);
    endfunction

endpackage

// File: rtl/partial_sum_accumulator_if.sv
// Product-in / result-out valid-ready bus for the partial-sum accumulator.
interface partial_sum_accumulator_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] product;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*ACC_W-1:0]  sum;
    logic [LANES-1:0]        ovf;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/partial_sum_accumulator_lane.sv
// One accumulator lane: sum register, adder, wrap or saturate (SATURATE_EN), sticky overflow.
module acc_lane #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              first,
    input  logic [DATA_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    localparam int unsigned EXT_W = ACC_W + 1;

    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;
    logic [ACC_W-1:0] base_c;
    logic [EXT_W-1:0] add_c;
    logic             carry_c;
    logic [ACC_W-1:0] sum_nxt_c;

    // The first term of a result starts from zero, so no explicit restart cycle is needed.
    always_comb begin
        base_c    = first ? '0 : sum_q;
        add_c     = EXT_W'(base_c) + EXT_W'(product);
        carry_c   = add_c[ACC_W];
`ifdef SATURATE_EN
        sum_nxt_c = carry_c ? '1 : add_c[ACC_W-1:0];
`else
        sum_nxt_c = add_c[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            sum_q <= sum_nxt_c;
            ovf_q <= carry_c | (ovf_q & ~first);
        end
    end

    assign sum = sum_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/partial_sum_accumulator.sv
// Multi-lane partial-sum accumulator: sums TERMS products per lane into one valid/ready result.
// Optional SATURATE_EN clamps lanes at full scale instead of wrapping.
module partial_sum_accumulator
    import acc_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned TERMS  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    partial_sum_accumulator_if.slave   bus
);
    localparam int unsigned CNT_W = cnt_width(TERMS);
    localparam int unsigned LAST  = TERMS - 1;

    acc_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   accept_c;
    logic                   first_c;
    logic [LANES*ACC_W-1:0] sum_w;
    logic [LANES-1:0]       ovf_w;

    // A product presented alongside clear is dropped.
    assign accept_c = bus.in_valid & in_ready_q & ~clear;
    assign first_c  = (cnt == '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (clear) begin
            state_nxt = ACCUM;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        if (cnt == CNT_W'(LAST)) begin
                            state_nxt = DONE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_nxt = ACCUM;
                    end
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // Handshake flags are registered copies of the next state, so in_ready stays low during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACCUM;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            in_ready_q  <= (state_nxt == ACCUM);
            out_valid_q <= (state_nxt == DONE);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        acc_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .accept  (accept_c),
            .first   (first_c),
            .product (bus.product[i*DATA_W +: DATA_W]),
            .sum     (sum_w[i*ACC_W +: ACC_W]),
            .ovf     (ovf_w[i])
        );
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_w;
    assign bus.ovf       = ovf_w;

endmodule

// File: tb/tb_partial_sum_accumulator.sv
// Bench for partial_sum_accumulator: directed cases plus random traffic vs a behavioural model.
module tb_partial_sum_accumulator;

    localparam int LANES  = 2;
    localparam int DATA_W = 8;
    localparam int TERMS  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] prod;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    partial_sum_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(12)) ifc ();
    partial_sum_accumulator_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(9))  ifc9 ();

    assign ifc.in_valid   = in_valid;
    assign ifc.product    = prod;
    assign ifc.out_ready  = out_ready;
    assign ifc9.in_valid  = in_valid;
    assign ifc9.product   = prod;
    assign ifc9.out_ready = out_ready;

    partial_sum_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(12), .TERMS(TERMS)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (ifc)
    );

    partial_sum_accumulator #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(9), .TERMS(TERMS)) dut9 (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (ifc9)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a result is the true sum of its terms, then wrapped or clamped to acc_w bits.
    function automatic void fold(input int total, input int acc_w, output int res, output int ov);
        int lim;
        lim = 1 << acc_w;
        ov  = (total >= lim) ? 1 : 0;
`ifdef SATURATE_EN
        res = (total >= lim) ? lim - 1 : total;
`else
        res = total % lim;
`endif
    endfunction

    // Model state
    bit started = 0;
    bit m_done, m_rdy, m_zero;
    int nterm;
    int tot[LANES];
    int m_res12[LANES], m_ovf12[LANES], m_res9[LANES], m_ovf9[LANES];

    always @(posedge clk) begin
        started = 1;
        if (reset || clear) begin
            m_done = 0;
            m_rdy  = !reset;
            m_zero = 1;
            nterm  = 0;
            for (int l = 0; l < LANES; l++) tot[l] = 0;
        end else if (m_done) begin
            if (out_ready) begin
                m_done = 0;
                m_rdy  = 1;
            end
        end else begin
            if (in_valid && m_rdy) begin
                for (int l = 0; l < LANES; l++) tot[l] += int'(prod[l*DATA_W +: DATA_W]);
                nterm++;
                m_zero = 0;
                if (nterm == TERMS) begin
                    for (int l = 0; l < LANES; l++) begin
                        fold(tot[l], 12, m_res12[l], m_ovf12[l]);
                        fold(tot[l], 9,  m_res9[l],  m_ovf9[l]);
                        tot[l] = 0;
                    end
                    nterm  = 0;
                    m_done = 1;
                    m_rdy  = 0;
                end
            end
            if (!m_done) m_rdy = 1;
        end
    end

    // Every-cycle comparison of both DUT builds against the model
    always @(negedge clk) begin
        if (started) begin
            check("out_valid",   int'(ifc.out_valid),  int'(m_done));
            check("in_ready",    int'(ifc.in_ready),   int'(m_rdy));
            check("out_valid9",  int'(ifc9.out_valid), int'(m_done));
            check("in_ready9",   int'(ifc9.in_ready),  int'(m_rdy));
            if (m_done || m_zero) begin
                for (int l = 0; l < LANES; l++) begin
                    check($sformatf("sum12_l%0d", l), int'(ifc.sum[l*12 +: 12]), m_zero ? 0 : m_res12[l]);
                    check($sformatf("ovf12_l%0d", l), int'(ifc.ovf[l]),          m_zero ? 0 : m_ovf12[l]);
                    check($sformatf("sum9_l%0d", l),  int'(ifc9.sum[l*9 +: 9]),  m_zero ? 0 : m_res9[l]);
                    check($sformatf("ovf9_l%0d", l),  int'(ifc9.ovf[l]),         m_zero ? 0 : m_ovf9[l]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one product word and return on the negedge after it is accepted.
    task automatic send(input int a, input int b);
        int n;
        logic [7:0] a8, b8;
        n = 0;
        a8 = 8'(a);
        b8 = 8'(b);
        in_valid = 1'b1;
        prod     = {b8, a8};
        while (!ifc.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        while (!ifc.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int gap_pat[7];
        logic [7:0] r0, r1;
        int exp_wrap, exp_sat;
        gap_pat = '{1, 0, 0, 1, 1, 0, 1};
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; prod = '0;
        repeat (2) tick();
        check("rst_out_valid", int'(ifc.out_valid), 0);
        check("rst_in_ready",  int'(ifc.in_ready),  0);
        check("rst_sum",       int'(ifc.sum),       0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", int'(ifc.in_ready), 1);

        // Basic back-to-back result
        send(10, 1); send(20, 2); send(30, 3); send(40, 4);
        check("basic_valid",   int'(ifc.out_valid),   1);
        check("basic_inrdy",   int'(ifc.in_ready),    0);
        check("basic_sum0",    int'(ifc.sum[11:0]),   100);
        check("basic_sum1",    int'(ifc.sum[23:12]),  10);
        check("basic_ovf",     int'(ifc.ovf),         0);
        check("model_sum0",    m_res12[0],            100);
        check("model_sum1",    m_res12[1],            10);
        tick();
        check("bubble_valid",  int'(ifc.out_valid),   0);
        check("bubble_inrdy",  int'(ifc.in_ready),    1);

        // Backpressure with ignored products
        out_ready = 1'b0;
        send(5, 1); send(6, 1); send(7, 1); send(8, 1);
        in_valid = 1'b1;
        prod     = {8'd99, 8'd99};
        repeat (5) begin
            tick();
            check("bp_valid", int'(ifc.out_valid),  1);
            check("bp_inrdy", int'(ifc.in_ready),   0);
            check("bp_sum0",  int'(ifc.sum[11:0]),  26);
        end
        drain();
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        check("bp_next_sum0", int'(ifc.sum[11:0]), 10);
        drain();

        // Gaps in in_valid
        for (int i = 0; i < 7; i++) begin
            in_valid = gap_pat[i] != 0;
            prod     = {8'd5, 8'd5};
            tick();
        end
        in_valid = 1'b0;
        check("gap_valid", int'(ifc.out_valid),  1);
        check("gap_sum0",  int'(ifc.sum[11:0]),  20);
        check("gap_sum1",  int'(ifc.sum[23:12]), 20);
        drain();

        // Overflow on the 9-bit instance only
        send(255, 1); send(255, 1); send(255, 1); send(255, 1);
`ifdef SATURATE_EN
        exp_sat = 511;
        check("ovf9_sum0",   int'(ifc9.sum[8:0]), exp_sat);
        check("model9_sum0", m_res9[0],           511);
`else
        exp_wrap = 508;
        check("ovf9_sum0",   int'(ifc9.sum[8:0]), exp_wrap);
        check("model9_sum0", m_res9[0],           508);
`endif
        check("ovf9_flag0",  int'(ifc9.ovf[0]),    1);
        check("ovf9_sum1",   int'(ifc9.sum[17:9]), 4);
        check("ovf9_flag1",  int'(ifc9.ovf[1]),    0);
        check("ovf12_sum0",  int'(ifc.sum[11:0]),  1020);
        check("ovf12_flags", int'(ifc.ovf),        0);
        drain();

        // Clear drops the partial sum and the product presented with it
        send(7, 7); send(7, 7);
        clear    = 1'b1;
        in_valid = 1'b1;
        prod     = {8'd50, 8'd50};
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_sum", int'(ifc.sum), 0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        check("clr_sum0", int'(ifc.sum[11:0]), 10);
        check("clr_ovf",  int'(ifc.ovf),       0);
        drain();

        // Reset while a result is pending
        out_ready = 1'b0;
        send(9, 9); send(9, 9); send(9, 9); send(9, 9);
        check("pre_rst_valid", int'(ifc.out_valid), 1);
        reset = 1'b1;
        tick();
        check("midrst_valid", int'(ifc.out_valid), 0);
        check("midrst_sum",   int'(ifc.sum),       0);
        check("midrst_ovf9",  int'(ifc9.ovf),      0);
        check("midrst_inrdy", int'(ifc.in_ready),  0);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("midrst_inrdy_after", int'(ifc.in_ready), 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            prod      = {r1, r0};
            tick();
        end
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
